// File: rtl/pipe_share_pkg.sv
// ---------------------------------------------------------------------------
// pipe_share_pkg
//   Shared constants and types for the pipeline sharing controller.
//   - NREQ_DEF / WIDTH_DEF / DEPTH_DEF : defaults shared with register_pipeline
//   - tag_w()  : index width for n requesters (never below 1)
//   - shadow_t : one in-flight tracking entry {vld, tag}
// ---------------------------------------------------------------------------
package pipe_share_pkg;
   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 3;
   localparam int NREQ_MAX  = 8;

   function automatic int tag_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int TAG_W    = tag_w(NREQ_DEF);
   // Shadow tag is sized for the largest legal NREQ so the struct is fixed.
   localparam int SH_TAG_W = tag_w(NREQ_MAX);

   typedef struct packed {
      logic                vld;
      logic [SH_TAG_W-1:0] tag;
   } shadow_t;

   localparam int SHADOW_W = $bits(shadow_t);
endpackage

// File: rtl/pipeline_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_share_ctrl_if
//   Requester-side bundle of the pipeline sharing controller.
//   req_valid/req_data/req_ready : per-requester beat handshake
//   resp_valid/resp_data         : one-hot returning word, no backpressure
//   master : requester side, slave : controller side
// ---------------------------------------------------------------------------
interface pipeline_share_ctrl_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       resp_valid;
   logic [WIDTH-1:0]      resp_data;

   modport master (output req_valid, req_data, input req_ready, resp_valid, resp_data);
   modport slave  (input req_valid, req_data, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: first set bit of req_i searching
//   ptr_i, ptr_i+1, ... mod NREQ.
//   req_i : request vector       ptr_i : search start index
//   gnt_o : one-hot grant        idx_o : granted index   any_o : grant exists
// ---------------------------------------------------------------------------
module rr_arbiter import pipe_share_pkg::*; #(
   parameter int NREQ  = NREQ_DEF,
   parameter int IDX_W = tag_w(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);
   always_comb begin
      int   j;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
      any_o = found;
   end
endmodule

// File: rtl/pipeline_share_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_share_ctrl
//   Shares one fixed-latency, non-stallable register_pipeline between NREQ
//   requesters. One beat per clock is granted round-robin; a shadow {vld,tag}
//   shift register of the same depth as the pipeline tells which requester
//   each returning word belongs to.
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : requester handshake and response bundle
//   pause         : 1 = issue no new grants (in-flight beats still drain)
//   pipe_datain   : to register_pipeline.datain (0 on bubbles)
//   pipe_dataout  : from register_pipeline.dataout
//   idle          : no beat in flight
//   beat_count    : accepted beats since reset, wraps
// ---------------------------------------------------------------------------
module pipeline_share_ctrl import pipe_share_pkg::*; #(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_share_ctrl_if.slave bus,
   input  logic                 pause,
   output logic [WIDTH-1:0]     pipe_datain,
   input  logic [WIDTH-1:0]     pipe_dataout,
   output logic                 idle,
   output logic [15:0]          beat_count
);
   localparam int PTR_W = tag_w(NREQ);

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [15:0]       cnt_q, cnt_d;
   shadow_t [DEPTH-1:0] sh_q, sh_d;

   logic [NREQ-1:0]   req_en;
   logic [NREQ-1:0]   arb_gnt;
   logic [PTR_W-1:0]  arb_idx;
   logic              arb_any;
   logic              inflight;

   // Reset and pause mask requests before arbitration, so no grant can leak.
   assign req_en = (rst_n && !pause) ? bus.req_valid : '0;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(PTR_W)) u_arb (
      .req_i (req_en),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign bus.req_ready = arb_gnt;
   assign pipe_datain   = arb_any ? bus.req_data[int'(arb_idx)*WIDTH +: WIDTH] : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      if (arb_any) begin
         rr_ptr_d = (arb_idx == PTR_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;
         cnt_d    = cnt_q + 16'd1;
      end
   end

   // Stage 0 captures the beat launched this edge; later stages mirror the
   // pipeline so stage DEPTH-1 lines up with pipe_dataout.
   always_comb begin
      sh_d        = sh_q;
      sh_d[0].vld = arb_any;
      sh_d[0].tag = arb_any ? SH_TAG_W'(arb_idx) : '0;
      for (int i = 1; i < DEPTH; i++) sh_d[i] = sh_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         sh_q     <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
      end
   end

   always_comb begin
      inflight = 1'b0;
      for (int i = 0; i < DEPTH; i++) inflight = inflight | sh_q[i].vld;
   end

   assign idle       = !rst_n || !inflight;
   assign beat_count = cnt_q;

   // Response decode straight from the last stage; no extra register.
   assign bus.resp_valid = (rst_n && sh_q[DEPTH-1].vld) ? (NREQ'(1) << sh_q[DEPTH-1].tag) : '0;
   assign bus.resp_data  = pipe_dataout;
endmodule
